uop_decode_q: RTL and testbench
===============================

UOP_DECODE_Q -- requirements
Module: uop_decode_q

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have parameter Q_DEPTH, default 4, decoded-uop queue entries; power of 2, >=2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush_in  input  1  discard all queued uops.
REQ-006 SHALL have port valid_instr_in  input  1  instr_in/pc_in valid.
REQ-007 SHALL have port instr_in  input  XLEN  raw RV32 instruction.
REQ-008 SHALL have port pc_in  input  XLEN  instruction address.
REQ-009 SHALL have port instr_ready_out  output  1  decoder accepts an instruction this cycle.
REQ-010 SHALL have port uop_valid_out  output  1  queue head valid.
REQ-011 SHALL have port uop_ready_in  input  1  backend consumes the head.
REQ-012 SHALL have ports uop_out (7), eoi_out (1), imm_out (XLEN), use_imm_out (1), pc_out (XLEN), except_out (1), src1_arch_out (5), src2_arch_out (5), dest_arch_out (5); all outputs, queue-head fields.
REQ-013 SHALL have port halted_out  output  1  sticky halt flag.
REQ-014 SHALL have port count_out  output  $clog2(Q_DEPTH+1)  current queue occupancy.

Function
REQ-015 SHALL drive instr_ready_out = !full && !halted && !flush_in; an instruction is accepted when valid_instr_in && instr_ready_out.
REQ-016 SHALL write the decoded uop into the queue at the accepting edge; the uop is visible at the head no earlier than the following cycle (1-cycle latency from empty).
REQ-017 SHALL pop the head when uop_valid_out && uop_ready_in; pushes and pops in the same cycle both take effect and leave count unchanged.
REQ-018 SHALL not accept a push while full, even if a pop occurs in the same cycle.
REQ-019 SHALL wrap the read and write pointers modulo Q_DEPTH.
REQ-020 SHALL set eoi_out=1 and pc_out=pc_in for every queued uop.
REQ-021 SHALL encode uop_out as {class[2:0], sub[3:0]}: ALU class 3'b010, MUL class 3'b100, HALT 7'h7F, illegal 7'h00.
REQ-022 LUI (opcode 0110111): ALU, sub=4'b0000, imm={instr[31:12],12'b0}, use_imm=1, src1=0, src2=0, dest=rd.
REQ-023 AUIPC (0010111): as LUI except imm=pc_in+{instr[31:12],12'b0}, computed modulo 2^32.
REQ-024 OP-IMM (0010011): ALU, sub={instr[30]&(funct3==3'b101), funct3}, imm=sign-extended instr[31:20], use_imm=1, src1=rs1, src2=0, dest=rd.
REQ-025 OP (0110011, funct7=0000000 or 0100000): ALU, sub={instr[30], funct3}, use_imm=0, imm=0, src1=rs1, src2=rs2, dest=rd.
REQ-026 M-ext (0110011, funct7=0000001): MUL, sub={1'b0, funct3}, use_imm=0, imm=0, src1=rs1, src2=rs2, dest=rd.
REQ-027 Any other encoding SHALL queue uop 7'h00 with except_out=1 and all register/immediate fields zero; the decoder continues accepting instructions.
REQ-028 instr_in==32'hDEADBEEF SHALL queue the HALT uop (except=0, all other fields zero) and set halted on the same edge; halted stays set until rst.
REQ-029 flush_in SHALL, at the edge, empty the queue (count=0, pointers equal), ignore any pop that cycle, and accept no instruction; halted is unaffected.
REQ-030 When the queue is empty, uop_valid_out SHALL be 0; the head fields are don't-care but must not be X after reset.

Reset
REQ-031 On rst: queue empty, count_out=0, uop_valid_out=0, halted_out=0, and all head fields 0; rst overrides flush_in, push and pop in the same cycle.
REQ-032 rst asserted mid-operation SHALL discard all queued uops with no further output.

Verification
REQ-033 ADDI x5,x1,-1 (0xFFF08293) @pc=0x100 -> next cycle uop=7'h20, imm=0xFFFFFFFF, use_imm=1, src1=1, dest=5, pc_out=0x100.
REQ-034 uop_ready_in=0, Q_DEPTH+1 valid ADDs -> count_out=Q_DEPTH, instr_ready_out=0; a single pop re-enables instr_ready_out in the next cycle; pops return FIFO order.
REQ-035 Sustained push and pop with occupancy 2 for 3*Q_DEPTH cycles -> count stays 2, no loss or duplication across pointer wrap.
REQ-036 MUL x3,x1,x2 (0x022081B3) -> uop=7'h40; SUB (0x402081B3) -> uop=7'h28; instr 0xFFFFFFFF -> uop=7'h00, except=1.
REQ-037 0xDEADBEEF -> HALT uop 7'h7F queued, halted_out=1, instr_ready_out=0 until rst; a flush clears the queue but halted_out remains 1.
REQ-038 Queue of 3 entries, flush_in and uop_ready_in both asserted -> count_out=0 next cycle; rst with a full queue -> uop_valid_out=0 next cycle.

Source files
------------

// File: rtl/uop_decode_q_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uop_decode_q_if : instruction-in / decoded-uop-out handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface uop_decode_q_if #(
  parameter int XLEN = 32
);
  logic            valid_instr_in;
  logic [XLEN-1:0] instr_in;
  logic [XLEN-1:0] pc_in;
  logic            instr_ready_out;
  logic            uop_valid_out;
  logic            uop_ready_in;
  logic [6:0]      uop_out;
  logic            eoi_out;
  logic [XLEN-1:0] imm_out;
  logic            use_imm_out;
  logic [XLEN-1:0] pc_out;
  logic            except_out;
  logic [4:0]      src1_arch_out;
  logic [4:0]      src2_arch_out;
  logic [4:0]      dest_arch_out;

  modport master (
    output valid_instr_in, instr_in, pc_in, uop_ready_in,
    input  instr_ready_out, uop_valid_out, uop_out, eoi_out, imm_out,
           use_imm_out, pc_out, except_out, src1_arch_out, src2_arch_out,
           dest_arch_out
  );

  modport slave (
    input  valid_instr_in, instr_in, pc_in, uop_ready_in,
    output instr_ready_out, uop_valid_out, uop_out, eoi_out, imm_out,
           use_imm_out, pc_out, except_out, src1_arch_out, src2_arch_out,
           dest_arch_out
  );
endinterface
`default_nettype wire

// File: rtl/uop_decode_q.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uop_decode_q : RV32I/M decoder feeding a small FIFO of decoded uops
// Rev 1.0
// ---------------------------------------------------------------------------
module uop_decode_q #(
  parameter int XLEN    = 32,
  parameter int Q_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_in,
  uop_decode_q_if.slave                bus,
  output logic                         halted_out,
  output logic [$clog2(Q_DEPTH+1)-1:0] count_out
);

  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = $clog2(Q_DEPTH + 1);

  localparam logic [XLEN-1:0] HALT_INSTR = 32'hDEADBEEF;
  localparam logic [6:0]      OPC_LUI    = 7'b0110111;
  localparam logic [6:0]      OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]      OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]      OPC_OP     = 7'b0110011;
  localparam logic [2:0]      CLS_ALU    = 3'b010;
  localparam logic [2:0]      CLS_MUL    = 3'b100;
  localparam logic [6:0]      UOP_HALT   = 7'h7F;

  typedef struct packed {
    logic [6:0]      uop;
    logic            eoi;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic [XLEN-1:0] pc;
    logic            except;
    logic [4:0]      src1;
    logic [4:0]      src2;
    logic [4:0]      dest;
  } entry_t;

  entry_t          mem [Q_DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            halted;
  logic            full;
  logic            push;
  logic            pop;
  logic            is_halt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode  = bus.instr_in[6:0];
  assign rd      = bus.instr_in[11:7];
  assign funct3  = bus.instr_in[14:12];
  assign rs1     = bus.instr_in[19:15];
  assign rs2     = bus.instr_in[24:20];
  assign funct7  = bus.instr_in[31:25];
  assign is_halt = (bus.instr_in == HALT_INSTR);

  // Anything not matched below stays an illegal uop with only pc/eoi set.
  always_comb begin
    dec        = '0;
    dec.eoi    = 1'b1;
    dec.pc     = bus.pc_in;
    dec.except = 1'b1;
    if (is_halt) begin
      dec.uop    = UOP_HALT;
      dec.except = 1'b0;
    end else begin
      case (opcode)
        OPC_LUI, OPC_AUIPC: begin
          dec.uop     = {CLS_ALU, 4'b0000};
          dec.imm     = {bus.instr_in[31:12], 12'b0};
          if (opcode == OPC_AUIPC) begin
            dec.imm = bus.pc_in + {bus.instr_in[31:12], 12'b0};
          end
          dec.use_imm = 1'b1;
          dec.dest    = rd;
          dec.except  = 1'b0;
        end
        OPC_OPIMM: begin
          dec.uop     = {CLS_ALU, bus.instr_in[30] & (funct3 == 3'b101), funct3};
          dec.imm     = {{(XLEN-12){bus.instr_in[31]}}, bus.instr_in[31:20]};
          dec.use_imm = 1'b1;
          dec.src1    = rs1;
          dec.dest    = rd;
          dec.except  = 1'b0;
        end
        OPC_OP: begin
          if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
            dec.uop    = {CLS_ALU, bus.instr_in[30], funct3};
            dec.src1   = rs1;
            dec.src2   = rs2;
            dec.dest   = rd;
            dec.except = 1'b0;
          end else if (funct7 == 7'b0000001) begin
            dec.uop    = {CLS_MUL, 1'b0, funct3};
            dec.src1   = rs1;
            dec.src2   = rs2;
            dec.dest   = rd;
            dec.except = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign full                = (count == CW'(Q_DEPTH));
  assign bus.instr_ready_out = !full && !halted && !flush_in;
  assign bus.uop_valid_out   = (count != '0);
  assign push                = bus.valid_instr_in && bus.instr_ready_out;
  assign pop                 = bus.uop_valid_out && bus.uop_ready_in && !flush_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      halted <= 1'b0;
      for (int i = 0; i < Q_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + PW'(1);
        if (is_halt) begin
          halted <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign head              = mem[rd_ptr];
  assign bus.uop_out       = head.uop;
  assign bus.eoi_out       = head.eoi;
  assign bus.imm_out       = head.imm;
  assign bus.use_imm_out   = head.use_imm;
  assign bus.pc_out        = head.pc;
  assign bus.except_out    = head.except;
  assign bus.src1_arch_out = head.src1;
  assign bus.src2_arch_out = head.src2;
  assign bus.dest_arch_out = head.dest;
  assign halted_out        = halted;
  assign count_out         = count;

endmodule
`default_nettype wire

// File: tb/tb_uop_decode_q.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uop_decode_q : scoreboard bench for the decoder/uop queue
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uop_decode_q;
  localparam int XLEN    = 32;
  localparam int Q_DEPTH = 4;
  localparam int CW      = $clog2(Q_DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_in;
  logic          halted_out;
  logic [CW-1:0] count_out;

  uop_decode_q_if #(.XLEN(XLEN)) bus ();

  uop_decode_q #(.XLEN(XLEN), .Q_DEPTH(Q_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_in   (flush_in),
    .bus        (bus),
    .halted_out (halted_out),
    .count_out  (count_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  uop;
    logic        eoi;
    logic [31:0] imm;
    logic        use_imm;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input logic [6:0] uop, input logic [31:0] imm,
                              input logic use_imm, input logic [31:0] pc,
                              input logic exc, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [4:0] d);
    exp_t e;
    e.uop = uop; e.eoi = 1'b1; e.imm = imm; e.use_imm = use_imm;
    e.pc = pc; e.exc = exc; e.s1 = s1; e.s2 = s2; e.d = d;
    return e;
  endfunction

  function automatic logic [31:0] add_enc(input logic [4:0] rd);
    return {7'b0000000, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] addi_enc(input int k);
    return {12'(k), 5'd1, 3'b000, 5'd3, 7'b0010011};
  endfunction

  // Consumer side of the scoreboard: every accepted pop must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t got;
    exp_t want;
    if (!rst && !flush_in && bus.uop_valid_out && bus.uop_ready_in) begin
      got = {bus.uop_out, bus.eoi_out, bus.imm_out, bus.use_imm_out, bus.pc_out,
             bus.except_out, bus.src1_arch_out, bus.src2_arch_out, bus.dest_arch_out};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got uop record %h, required no output", got);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL uop_head: got %h, required %h", got, want);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_instr_in = 1'b0;
    bus.instr_in       = '0;
    bus.pc_in          = '0;
    bus.uop_ready_in   = 1'b0;
    flush_in           = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) tick();
    checks++; if (count_out !== '0) begin errors++; $display("FAIL rst_count: got %0d, required 0", count_out); end
    checks++; if (bus.uop_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", bus.uop_valid_out); end
    checks++; if (halted_out !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b, required 0", halted_out); end
    checks++;
    if ({bus.uop_out, bus.eoi_out, bus.imm_out, bus.use_imm_out, bus.pc_out, bus.except_out,
         bus.src1_arch_out, bus.src2_arch_out, bus.dest_arch_out} !== '0) begin
      errors++; $display("FAIL rst_head: got uop %h imm %h pc %h, required all zero", bus.uop_out, bus.imm_out, bus.pc_out);
    end
    rst = 1'b0;
    #1;
    checks++; if (bus.instr_ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", bus.instr_ready_out); end
    tick();
  endtask

  task automatic test_addi();
    bus.valid_instr_in = 1'b1;
    bus.instr_in       = 32'hFFF08293;
    bus.pc_in          = 32'h100;
    #1;
    checks++; if (bus.uop_valid_out !== 1'b0) begin errors++; $display("FAIL addi_pre_valid: got %b, required 0", bus.uop_valid_out); end
    sb.push_back(mk(7'h20, 32'hFFFFFFFF, 1'b1, 32'h100, 1'b0, 5'd1, 5'd0, 5'd5));
    tick();
    bus.valid_instr_in = 1'b0;
    checks++; if (bus.uop_valid_out !== 1'b1) begin errors++; $display("FAIL addi_latency: got %b, required 1", bus.uop_valid_out); end
    checks++; if (count_out !== CW'(1)) begin errors++; $display("FAIL addi_count: got %0d, required 1", count_out); end
    bus.uop_ready_in = 1'b1;
    tick();
    bus.uop_ready_in = 1'b0;
    checks++; if (count_out !== '0) begin errors++; $display("FAIL addi_drain: got %0d, required 0", count_out); end
  endtask

  task automatic test_full();
    bus.uop_ready_in = 1'b0;
    for (int i = 0; i <= Q_DEPTH; i++) begin
      bus.valid_instr_in = 1'b1;
      bus.instr_in       = add_enc(5'(i + 1));
      bus.pc_in          = 32'h200 + 32'(4 * i);
      #1;
      checks++;
      if (bus.instr_ready_out !== 1'(i < Q_DEPTH)) begin
        errors++; $display("FAIL full_ready_%0d: got %b, required %b", i, bus.instr_ready_out, 1'(i < Q_DEPTH));
      end
      if (i < Q_DEPTH) sb.push_back(mk(7'h20, 32'h0, 1'b0, bus.pc_in, 1'b0, 5'd1, 5'd2, 5'(i + 1)));
      tick();
    end
    checks++; if (count_out !== CW'(Q_DEPTH)) begin errors++; $display("FAIL full_count: got %0d, required %0d", count_out, Q_DEPTH); end
    checks++; if (bus.instr_ready_out !== 1'b0) begin errors++; $display("FAIL full_not_ready: got %b, required 0", bus.instr_ready_out); end
    // Pop while full with a valid instruction offered: it must not be taken.
    bus.uop_ready_in = 1'b1;
    tick();
    checks++; if (count_out !== CW'(Q_DEPTH - 1)) begin errors++; $display("FAIL full_pop_count: got %0d, required %0d", count_out, Q_DEPTH - 1); end
    checks++; if (bus.instr_ready_out !== 1'b1) begin errors++; $display("FAIL full_reenable: got %b, required 1", bus.instr_ready_out); end
    bus.valid_instr_in = 1'b0;
    repeat (Q_DEPTH - 1) tick();
    bus.uop_ready_in = 1'b0;
    checks++; if (count_out !== '0) begin errors++; $display("FAIL full_drain: got %0d, required 0", count_out); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_sb_left: got %0d entries, required 0", sb.size()); end
  endtask

  task automatic test_stream();
    for (int n = 0; n < 2 + 3 * Q_DEPTH; n++) begin
      bus.valid_instr_in = 1'b1;
      bus.instr_in       = addi_enc(n);
      bus.pc_in          = 32'h300 + 32'(4 * n);
      bus.uop_ready_in   = (n >= 2);
      sb.push_back(mk(7'h20, 32'(n), 1'b1, bus.pc_in, 1'b0, 5'd1, 5'd0, 5'd3));
      tick();
      if (n >= 2) begin
        checks++; if (count_out !== CW'(2)) begin errors++; $display("FAIL stream_count_%0d: got %0d, required 2", n, count_out); end
      end
    end
    bus.valid_instr_in = 1'b0;
    bus.uop_ready_in   = 1'b1;
    repeat (2) tick();
    bus.uop_ready_in = 1'b0;
    checks++; if (count_out !== '0) begin errors++; $display("FAIL stream_drain: got %0d, required 0", count_out); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_sb_left: got %0d entries, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [7];
    logic [31:0] pcs [7];
    exp_t        ex  [7];
    ins = '{32'h022081B3, 32'h402081B3, 32'hFFFFFFFF, 32'h123452B7,
            32'h00001297, 32'h4030D193, 32'h00112023};
    pcs = '{32'h500, 32'h504, 32'h508, 32'h50C, 32'hFFFFF800, 32'h514, 32'h518};
    ex[0] = mk(7'h40, 32'h0,        1'b0, pcs[0], 1'b0, 5'd1, 5'd2, 5'd3);
    ex[1] = mk(7'h28, 32'h0,        1'b0, pcs[1], 1'b0, 5'd1, 5'd2, 5'd3);
    ex[2] = mk(7'h00, 32'h0,        1'b0, pcs[2], 1'b1, 5'd0, 5'd0, 5'd0);
    ex[3] = mk(7'h20, 32'h12345000, 1'b1, pcs[3], 1'b0, 5'd0, 5'd0, 5'd5);
    ex[4] = mk(7'h20, 32'h00000800, 1'b1, pcs[4], 1'b0, 5'd0, 5'd0, 5'd5);
    ex[5] = mk(7'h2D, 32'h00000403, 1'b1, pcs[5], 1'b0, 5'd1, 5'd0, 5'd3);
    ex[6] = mk(7'h00, 32'h0,        1'b0, pcs[6], 1'b1, 5'd0, 5'd0, 5'd0);
    bus.uop_ready_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.valid_instr_in = 1'b1;
      bus.instr_in       = ins[i];
      bus.pc_in          = pcs[i];
      #1;
      checks++; if (bus.instr_ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b, required 1", i, bus.instr_ready_out); end
      sb.push_back(ex[i]);
      tick();
    end
    bus.valid_instr_in = 1'b0;
    tick();
    bus.uop_ready_in = 1'b0;
    checks++; if (count_out !== '0) begin errors++; $display("FAIL b2b_drain: got %0d, required 0", count_out); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_sb_left: got %0d entries, required 0", sb.size()); end
  endtask

  task automatic test_flush();
    bus.uop_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.valid_instr_in = 1'b1;
      bus.instr_in       = add_enc(5'(10 + i));
      bus.pc_in          = 32'h600 + 32'(4 * i);
      tick();
    end
    checks++; if (count_out !== CW'(3)) begin errors++; $display("FAIL flush_fill: got %0d, required 3", count_out); end
    flush_in         = 1'b1;
    bus.uop_ready_in = 1'b1;
    bus.instr_in     = add_enc(5'd20);
    #1;
    checks++; if (bus.instr_ready_out !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b, required 0", bus.instr_ready_out); end
    tick();
    idle();
    checks++; if (count_out !== '0) begin errors++; $display("FAIL flush_count: got %0d, required 0", count_out); end
    checks++; if (bus.uop_valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, required 0", bus.uop_valid_out); end
    tick();
    checks++; if (count_out !== '0) begin errors++; $display("FAIL flush_stale: got %0d, required 0", count_out); end
  endtask

  task automatic test_halt();
    bus.uop_ready_in   = 1'b0;
    bus.valid_instr_in = 1'b1;
    bus.instr_in       = add_enc(5'd7);
    bus.pc_in          = 32'h400;
    sb.push_back(mk(7'h20, 32'h0, 1'b0, 32'h400, 1'b0, 5'd1, 5'd2, 5'd7));
    tick();
    bus.instr_in = 32'hDEADBEEF;
    bus.pc_in    = 32'h404;
    sb.push_back(mk(7'h7F, 32'h0, 1'b0, 32'h404, 1'b0, 5'd0, 5'd0, 5'd0));
    tick();
    checks++; if (halted_out !== 1'b1) begin errors++; $display("FAIL halt_set: got %b, required 1", halted_out); end
    checks++; if (bus.instr_ready_out !== 1'b0) begin errors++; $display("FAIL halt_ready: got %b, required 0", bus.instr_ready_out); end
    checks++; if (count_out !== CW'(2)) begin errors++; $display("FAIL halt_count: got %0d, required 2", count_out); end
    bus.instr_in = add_enc(5'd8);
    bus.pc_in    = 32'h408;
    bus.uop_ready_in = 1'b1;
    repeat (3) tick();
    bus.uop_ready_in = 1'b0;
    checks++; if (count_out !== '0) begin errors++; $display("FAIL halt_no_accept: got %0d, required 0", count_out); end
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    checks++; if (halted_out !== 1'b1) begin errors++; $display("FAIL halt_after_flush: got %b, required 1", halted_out); end
    checks++; if (bus.instr_ready_out !== 1'b0) begin errors++; $display("FAIL halt_flush_ready: got %b, required 0", bus.instr_ready_out); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL halt_sb_left: got %0d entries, required 0", sb.size()); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (halted_out !== 1'b0) begin errors++; $display("FAIL halt_rst: got %b, required 0", halted_out); end
    checks++; if (bus.instr_ready_out !== 1'b1) begin errors++; $display("FAIL halt_rst_ready: got %b, required 1", bus.instr_ready_out); end
  endtask

  task automatic test_rst_full();
    bus.uop_ready_in = 1'b0;
    for (int i = 0; i < Q_DEPTH; i++) begin
      bus.valid_instr_in = 1'b1;
      bus.instr_in       = add_enc(5'(i + 1));
      bus.pc_in          = 32'h700 + 32'(4 * i);
      tick();
    end
    checks++; if (count_out !== CW'(Q_DEPTH)) begin errors++; $display("FAIL rstf_fill: got %0d, required %0d", count_out, Q_DEPTH); end
    rst              = 1'b1;
    bus.uop_ready_in = 1'b1;
    tick();
    rst = 1'b0;
    bus.valid_instr_in = 1'b0;
    checks++; if (bus.uop_valid_out !== 1'b0) begin errors++; $display("FAIL rstf_valid: got %b, required 0", bus.uop_valid_out); end
    checks++; if (count_out !== '0) begin errors++; $display("FAIL rstf_count: got %0d, required 0", count_out); end
    checks++; if (bus.uop_out !== 7'h00) begin errors++; $display("FAIL rstf_head: got %h, required 00", bus.uop_out); end
    repeat (2) tick();
    checks++; if (bus.uop_valid_out !== 1'b0) begin errors++; $display("FAIL rstf_quiet: got %b, required 0", bus.uop_valid_out); end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_addi();
    test_full();
    test_stream();
    test_back_to_back();
    test_flush();
    test_halt();
    test_rst_full();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
